// File: rtl/main_memory_responder.sv
// Memory-side responder for the cache main_read/main_write/ready handshake.
// Holds each accepted access for LATENCY edges, then pulses ready for one cycle.
module main_memory_responder #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 10,
    parameter int BLOCK_WORDS = 4,
    parameter int LATENCY     = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          main_read,
    input  logic                          main_write,
    input  logic [ADDR_W-1:0]             addr,
    input  logic [DATA_W-1:0]             wdata,
    output logic                          ready,
    output logic [BLOCK_WORDS*DATA_W-1:0] rdata,
    output logic                          busy,
    output logic                          protocol_err
);
    localparam int OFF_W = $clog2(BLOCK_WORDS);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, RESPOND} state_t;

    state_t                          state;
    state_t                          state_next;
    logic [CNT_W-1:0]                cnt;
    logic [ADDR_W-1:0]               cap_addr;
    logic [DATA_W-1:0]               cap_data;
    logic [DATA_W-1:0]               mem [2**ADDR_W];
    logic [BLOCK_WORDS*DATA_W-1:0]   block_data;
    logic                            accept_rd;
    logic                            accept_wr;
    logic                            both_req;
    logic                            done;

    assign both_req  = (state == IDLE) & main_read & main_write;
    assign accept_rd = (state == IDLE) & main_read & ~main_write;
    assign accept_wr = (state == IDLE) & main_write & ~main_read;
    assign done      = (cnt == '0);

    always_comb begin
        state_next = state;
        ready      = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (accept_rd)      state_next = RD_WAIT;
                else if (accept_wr) state_next = WR_WAIT;
            end
            RD_WAIT, WR_WAIT: if (done) state_next = RESPOND;
            RESPOND: begin
                ready      = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Block base keeps only ADDR_W bits, so word indices never carry out of the block.
    always_comb begin
        block_data = '0;
        for (int i = 0; i < BLOCK_WORDS; i++)
            block_data[i*DATA_W +: DATA_W] = mem[{cap_addr[ADDR_W-1:OFF_W], OFF_W'(i)}];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            cnt          <= '0;
            rdata        <= '0;
            protocol_err <= 1'b0;
        end else begin
            state <= state_next;
            if (both_req)
                protocol_err <= 1'b1;
            if (accept_rd | accept_wr)
                cnt <= CNT_LOAD;
            else if ((state == RD_WAIT || state == WR_WAIT) && !done)
                cnt <= cnt - 1'b1;
            if (state == RD_WAIT && done)
                rdata <= block_data;
        end
    end

    // Array and capture registers carry no reset; a reset forces IDLE so no write can commit.
    always_ff @(posedge clk) begin
        if (accept_rd | accept_wr) begin
            cap_addr <= addr;
            cap_data <= wdata;
        end
        if (state == WR_WAIT && done)
            mem[cap_addr] <= cap_data;
    end
endmodule

// File: tb/tb_main_memory_responder.sv
// Randomized self-checking bench for main_memory_responder (LATENCY=4 and LATENCY=1 instances).
module tb_main_memory_responder;
    localparam int DW  = 32;
    localparam int AW  = 10;
    localparam int BW  = 4;
    localparam int LAT = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset, main_read, main_write;
    logic [AW-1:0]     addr;
    logic [DW-1:0]     wdata;
    logic              ready, busy, protocol_err;
    logic [BW*DW-1:0]  rdata;

    logic              f_reset, f_main_read, f_main_write;
    logic [AW-1:0]     f_addr;
    logic [DW-1:0]     f_wdata;
    logic              f_ready, f_busy, f_protocol_err;
    logic [BW*DW-1:0]  f_rdata;

    main_memory_responder #(.DATA_W(DW), .ADDR_W(AW), .BLOCK_WORDS(BW), .LATENCY(LAT)) dut (
        .clk(clk), .reset(reset), .main_read(main_read), .main_write(main_write),
        .addr(addr), .wdata(wdata), .ready(ready), .rdata(rdata), .busy(busy),
        .protocol_err(protocol_err)
    );

    main_memory_responder #(.DATA_W(DW), .ADDR_W(AW), .BLOCK_WORDS(BW), .LATENCY(1)) dut_fast (
        .clk(clk), .reset(f_reset), .main_read(f_main_read), .main_write(f_main_write),
        .addr(f_addr), .wdata(f_wdata), .ready(f_ready), .rdata(f_rdata), .busy(f_busy),
        .protocol_err(f_protocol_err)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [DW-1:0]    model_mem [1<<AW];
    logic [BW*DW-1:0] model_rdata = '0;

    function automatic logic [BW*DW-1:0] model_block(input logic [AW-1:0] a);
        logic [BW*DW-1:0] b;
        logic [AW-1:0]    base;
        base = a & ~AW'(BW - 1);
        for (int i = 0; i < BW; i++) b[i*DW +: DW] = model_mem[base + AW'(i)];
        return b;
    endfunction

    // Issue one request on the LATENCY=4 instance; drop_at<0 holds it until ready.
    task automatic transact(input bit is_rd, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input int drop_at, input string tag);
        int first_ready, n_ready, n_busy;
        main_read = is_rd; main_write = ~is_rd; addr = a; wdata = d;
        @(posedge clk); #1;
        first_ready = -1; n_ready = 0; n_busy = 0;
        for (int k = 0; k < 10; k++) begin
            if (busy) n_busy++;
            if (ready) begin
                n_ready++;
                if (first_ready < 0) first_ready = k;
            end
            if (ready || k == drop_at) begin
                main_read = 1'b0; main_write = 1'b0;
                addr = AW'($urandom); wdata = $urandom;
            end
            @(posedge clk); #1;
        end
        main_read = 1'b0; main_write = 1'b0;
        if (is_rd) model_rdata = model_block(a);
        else       model_mem[a] = d;
        n_cmp++;
        if (n_ready !== 1) begin n_bad++; $display("FAIL %s ready_count: got %0d expected 1", tag, n_ready); end
        n_cmp++;
        if (first_ready !== LAT) begin n_bad++; $display("FAIL %s ready_latency: got %0d expected %0d", tag, first_ready, LAT); end
        n_cmp++;
        if (n_busy !== LAT + 1) begin n_bad++; $display("FAIL %s busy_cycles: got %0d expected %0d", tag, n_busy, LAT + 1); end
        n_cmp++;
        if (rdata !== model_rdata) begin n_bad++; $display("FAIL %s rdata: got %h expected %h", tag, rdata, model_rdata); end
    endtask

    task automatic test_reset();
        reset = 1'b0; main_read = 1'b0; main_write = 1'b0; addr = '0; wdata = '0;
        f_reset = 1'b0; f_main_read = 1'b0; f_main_write = 1'b0; f_addr = '0; f_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b expected 0", ready); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_cmp++; if (protocol_err !== 1'b0) begin n_bad++; $display("FAIL reset_perr: got %b expected 0", protocol_err); end
        n_cmp++; if (rdata !== '0) begin n_bad++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
        reset = 1'b1; f_reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_write();
        transact(1'b0, 10'h005, 32'hDEADBEEF, -1, "write_deadbeef");
    endtask

    task automatic test_read();
        logic [BW*DW-1:0] exp_blk;
        transact(1'b0, 10'h004, 32'h11, -1, "fill4");
        transact(1'b0, 10'h005, 32'h22, -1, "fill5");
        transact(1'b0, 10'h006, 32'h33, -1, "fill6");
        transact(1'b0, 10'h007, 32'h44, -1, "fill7");
        transact(1'b1, 10'h006, '0, -1, "read6");
        exp_blk = {32'h44, 32'h33, 32'h22, 32'h11};
        n_cmp++; if (rdata !== exp_blk) begin n_bad++; $display("FAIL read6_const: got %h expected %h", rdata, exp_blk); end
        repeat (5) @(posedge clk);
        #1;
        n_cmp++; if (rdata !== exp_blk) begin n_bad++; $display("FAIL read6_stable: got %h expected %h", rdata, exp_blk); end
    endtask

    task automatic test_protocol();
        int bad_busy, bad_ready;
        bad_busy = 0; bad_ready = 0;
        main_read = 1'b1; main_write = 1'b1; addr = 10'h004;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (busy) bad_busy++;
            if (ready) bad_ready++;
        end
        n_cmp++; if (protocol_err !== 1'b1) begin n_bad++; $display("FAIL perr_set: got %b expected 1", protocol_err); end
        main_read = 1'b0; main_write = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        if (busy) bad_busy++;
        n_cmp++; if (bad_busy !== 0) begin n_bad++; $display("FAIL perr_busy: got %0d busy cycles expected 0", bad_busy); end
        n_cmp++; if (bad_ready !== 0) begin n_bad++; $display("FAIL perr_ready: got %0d pulses expected 0", bad_ready); end
        n_cmp++; if (protocol_err !== 1'b1) begin n_bad++; $display("FAIL perr_sticky: got %b expected 1", protocol_err); end
        transact(1'b1, 10'h004, '0, -1, "perr_then_read");
        n_cmp++; if (protocol_err !== 1'b1) begin n_bad++; $display("FAIL perr_after_read: got %b expected 1", protocol_err); end
    endtask

    task automatic test_drop();
        for (int i = 0; i < BW; i++) transact(1'b0, 10'h3FC + AW'(i), $urandom, -1, "fill_top");
        transact(1'b1, 10'h3FF, '0, 0, "drop_read_3ff");
    endtask

    task automatic test_reset_mid();
        int pulses;
        logic [DW-1:0] old_word;
        for (int i = 0; i < BW; i++) transact(1'b0, 10'h010 + AW'(i), $urandom, -1, "fill_10");
        old_word = model_mem[10'h010];
        main_write = 1'b1; addr = 10'h010; wdata = ~old_word;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL midrst_ready: got %b expected 0", ready); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        n_cmp++; if (protocol_err !== 1'b0) begin n_bad++; $display("FAIL midrst_perr: got %b expected 0", protocol_err); end
        n_cmp++; if (rdata !== '0) begin n_bad++; $display("FAIL midrst_rdata: got %h expected 0", rdata); end
        main_write = 1'b0;
        pulses = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (ready) pulses++;
        end
        reset = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (ready) pulses++;
        end
        n_cmp++; if (pulses !== 0) begin n_bad++; $display("FAIL midrst_no_ready: got %0d pulses expected 0", pulses); end
        model_rdata = '0;
        transact(1'b1, 10'h010, '0, -1, "midrst_read");
        n_cmp++; if (rdata[DW-1:0] !== old_word) begin n_bad++; $display("FAIL midrst_old_word: got %h expected %h", rdata[DW-1:0], old_word); end
    endtask

    task automatic test_random();
        logic [AW-1:0] a;
        int drop;
        for (int i = 0; i < 32; i++) transact(1'b0, 10'h100 + AW'(i), $urandom, -1, "rnd_fill");
        for (int n = 0; n < 40; n++) begin
            a = 10'h100 + AW'($urandom_range(0, 31));
            drop = $urandom_range(0, 6) - 1;
            transact(1'($urandom_range(0, 1)), a, $urandom, drop, "rnd_op");
        end
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        a = AW'($urandom);
        d = $urandom;
        f_main_write = 1'b1; f_addr = a; f_wdata = d;
        @(posedge clk); #1;
        n_cmp++; if (f_busy !== 1'b1 || f_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_wr_wait: got busy=%b ready=%b expected busy=1 ready=0", f_busy, f_ready); end
        @(posedge clk); #1;
        n_cmp++; if (f_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_wr_ready: got %b expected 1", f_ready); end
        f_main_write = 1'b0; f_main_read = 1'b1; f_wdata = ~d;
        @(posedge clk); #1;
        n_cmp++; if (f_busy !== 1'b0 || f_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_idle: got busy=%b ready=%b expected 0 0", f_busy, f_ready); end
        @(posedge clk); #1;
        n_cmp++; if (f_busy !== 1'b1 || f_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_rd_accept: got busy=%b ready=%b expected busy=1 ready=0", f_busy, f_ready); end
        @(posedge clk); #1;
        n_cmp++; if (f_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_rd_ready: got %b expected 1", f_ready); end
        f_main_read = 1'b0;
        n_cmp++;
        if (f_rdata[(int'(a) % BW)*DW +: DW] !== d) begin
            n_bad++;
            $display("FAIL b2b_rdata: got %h expected %h", f_rdata[(int'(a) % BW)*DW +: DW], d);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_protocol();
        test_drop();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
